// File: rtl/shift_cpu_top.sv
// Multi-cycle 8-bit CPU (6502 subset: loads, stores, shifts/rotates, flags, JMP) with its memory.
// Latency: 2-6 ph1 cycles per instruction, plus 2 cycles of reset-vector fetch after reset release.
// Backpressure: none; the core owns the single memory bus and issues one access per cycle.
//
// Ports:
//   ph1     in   1   system clock, all state on the rising edge
//   reset   in   1   synchronous active-low reset
//   pc      out  16  program counter (debug)
//   halted  out  1   set when an unimplemented opcode is fetched; cleared only by reset

// Memory for the CPU: combinational read, write on the clock edge.
// Latency: reads 0 cycles, writes land on the next ph1 edge.
// Backpressure: none; writes to ROM or to unmapped space are dropped.
module shift_cpu_mem #(
    parameter int ROM_AW = 12,
    parameter int RAM_AW = 9
) (
    input  logic              clk,
    input  logic [15:0]       addr,
    input  logic              we,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    // Program-load port: the only way ROM changes in hardware; the CPU bus cannot write it.
    input  logic              load_en,
    input  logic [ROM_AW-1:0] load_addr,
    input  logic [7:0]        load_dat
);
    logic [7:0] ROM [0:(1<<ROM_AW)-1];
    logic [7:0] RAM [0:(1<<RAM_AW)-1];

    logic rom_sel;
    logic ram_sel;

    // ROM sits at the top of the map, RAM at the bottom; everything between reads as zero.
    assign rom_sel = &addr[15:ROM_AW];
    assign ram_sel = ~|addr[15:RAM_AW];

    always_comb begin
        rdata = 8'h00;
        if (rom_sel)
            rdata = ROM[addr[ROM_AW-1:0]];
        else if (ram_sel)
            rdata = RAM[addr[RAM_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (we && ram_sel)
            RAM[addr[RAM_AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (load_en)
            ROM[load_addr] <= load_dat;
    end
endmodule

module shift_cpu_top #(
    parameter int          ROM_AW  = 12,
    parameter int          RAM_AW  = 9,
    parameter logic [15:0] RST_VEC = 16'hFFFC
) (
    input  logic        ph1,
    input  logic        reset,
    output logic [15:0] pc,
    output logic        halted
);
    typedef enum logic [3:0] {
        S_VEC_LO, S_VEC_HI, S_FETCH, S_OP_LO, S_OP_HI, S_READ, S_EXEC, S_WRITE, S_HALT
    } state_t;

    typedef enum logic [1:0] {M_IMP, M_IMM, M_ZP, M_ABS} mode_t;

    typedef enum logic [3:0] {
        O_LD, O_ST, O_ASL, O_LSR, O_ROL, O_ROR, O_CLC, O_SEC, O_NOP, O_JMP
    } op_t;

    typedef enum logic [1:0] {R_A, R_X, R_Y} rsel_t;

    typedef struct packed {
        logic  valid;
        mode_t mode;
        op_t   op;
        rsel_t rsel;
    } dec_t;

    function automatic dec_t decode(input logic [7:0] opc);
        dec_t d;
        d = '{1'b0, M_IMP, O_NOP, R_A};
        case (opc)
            8'hA9: d = '{1'b1, M_IMM, O_LD,  R_A};
            8'hA2: d = '{1'b1, M_IMM, O_LD,  R_X};
            8'hA0: d = '{1'b1, M_IMM, O_LD,  R_Y};
            8'hA5: d = '{1'b1, M_ZP,  O_LD,  R_A};
            8'hA6: d = '{1'b1, M_ZP,  O_LD,  R_X};
            8'hA4: d = '{1'b1, M_ZP,  O_LD,  R_Y};
            8'hAD: d = '{1'b1, M_ABS, O_LD,  R_A};
            8'hAE: d = '{1'b1, M_ABS, O_LD,  R_X};
            8'hAC: d = '{1'b1, M_ABS, O_LD,  R_Y};
            8'h85: d = '{1'b1, M_ZP,  O_ST,  R_A};
            8'h86: d = '{1'b1, M_ZP,  O_ST,  R_X};
            8'h84: d = '{1'b1, M_ZP,  O_ST,  R_Y};
            8'h8D: d = '{1'b1, M_ABS, O_ST,  R_A};
            8'h8E: d = '{1'b1, M_ABS, O_ST,  R_X};
            8'h8C: d = '{1'b1, M_ABS, O_ST,  R_Y};
            8'h0A: d = '{1'b1, M_IMP, O_ASL, R_A};
            8'h06: d = '{1'b1, M_ZP,  O_ASL, R_A};
            8'h0E: d = '{1'b1, M_ABS, O_ASL, R_A};
            8'h4A: d = '{1'b1, M_IMP, O_LSR, R_A};
            8'h46: d = '{1'b1, M_ZP,  O_LSR, R_A};
            8'h4E: d = '{1'b1, M_ABS, O_LSR, R_A};
            8'h2A: d = '{1'b1, M_IMP, O_ROL, R_A};
            8'h26: d = '{1'b1, M_ZP,  O_ROL, R_A};
            8'h2E: d = '{1'b1, M_ABS, O_ROL, R_A};
            8'h6A: d = '{1'b1, M_IMP, O_ROR, R_A};
            8'h66: d = '{1'b1, M_ZP,  O_ROR, R_A};
            8'h6E: d = '{1'b1, M_ABS, O_ROR, R_A};
            8'h18: d = '{1'b1, M_IMP, O_CLC, R_A};
            8'h38: d = '{1'b1, M_IMP, O_SEC, R_A};
            8'hEA: d = '{1'b1, M_IMP, O_NOP, R_A};
            8'h4C: d = '{1'b1, M_ABS, O_JMP, R_A};
            default: d = '{1'b0, M_IMP, O_NOP, R_A};
        endcase
        return d;
    endfunction

    state_t      state;
    logic [7:0]  a, x, y;
    logic        c, z, n;
    logic [7:0]  ir;
    logic [7:0]  oplo, ophi;
    logic [7:0]  md;            // memory data: operand, read data, or value to write back

    logic [15:0] addr;
    logic        we;
    logic [7:0]  rdata;
    logic [15:0] ea;
    dec_t        dec;
    logic        is_shift;
    logic        needs_read;
    logic [7:0]  sh_in, sh_res, st_val;
    logic        sh_c;

    assign ea = {ophi, oplo};

    // During FETCH the opcode is still on the bus, so decode it directly to pick the next state.
    assign dec        = decode((state == S_FETCH) ? rdata : ir);
    assign is_shift   = (dec.op == O_ASL) || (dec.op == O_LSR) || (dec.op == O_ROL) || (dec.op == O_ROR);
    assign needs_read = (dec.op == O_LD) || is_shift;

    always_comb begin
        addr = pc;
        case (state)
            S_VEC_LO:         addr = RST_VEC;
            S_VEC_HI:         addr = RST_VEC + 16'd1;
            S_READ, S_WRITE:  addr = ea;
            default:          addr = pc;
        endcase
    end

    // Gated by reset so an RMW interrupted in its WRITE cycle never commits.
    assign we = (state == S_WRITE) && reset;

    always_comb begin
        sh_in  = (dec.mode == M_IMP) ? a : md;
        sh_res = sh_in;
        sh_c   = c;
        case (dec.op)
            O_ASL: begin sh_c = sh_in[7]; sh_res = {sh_in[6:0], 1'b0}; end
            O_LSR: begin sh_c = sh_in[0]; sh_res = {1'b0, sh_in[7:1]}; end
            O_ROL: begin sh_c = sh_in[7]; sh_res = {sh_in[6:0], c};    end
            O_ROR: begin sh_c = sh_in[0]; sh_res = {c, sh_in[7:1]};    end
            default: begin sh_c = c; sh_res = sh_in; end
        endcase
    end

    always_comb begin
        case (dec.rsel)
            R_X:     st_val = x;
            R_Y:     st_val = y;
            default: st_val = a;
        endcase
    end

    shift_cpu_mem #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) mem (
        .clk       (ph1),
        .addr      (addr),
        .we        (we),
        .wdata     (md),
        .rdata     (rdata),
        .load_en   (1'b0),
        .load_addr ('0),
        .load_dat  (8'h00)
    );

    always_ff @(posedge ph1) begin
        if (!reset) begin
            state  <= S_VEC_LO;
            a      <= 8'h00;
            x      <= 8'h00;
            y      <= 8'h00;
            c      <= 1'b0;
            z      <= 1'b0;
            n      <= 1'b0;
            pc     <= 16'h0000;
            halted <= 1'b0;
            ir     <= 8'h00;
            oplo   <= 8'h00;
            ophi   <= 8'h00;
            md     <= 8'h00;
        end else begin
            case (state)
                S_VEC_LO: begin
                    oplo  <= rdata;
                    state <= S_VEC_HI;
                end
                S_VEC_HI: begin
                    pc    <= {rdata, oplo};
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    ir <= rdata;
                    pc <= pc + 16'd1;
                    if (!dec.valid) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (dec.mode == M_IMP) begin
                        state <= S_EXEC;
                    end else begin
                        state <= S_OP_LO;
                    end
                end
                S_OP_LO: begin
                    oplo <= rdata;
                    ophi <= 8'h00;      // zero page unless an OP_HI byte follows
                    md   <= rdata;      // immediate operand goes straight to EXEC
                    pc   <= pc + 16'd1;
                    if (dec.mode == M_ABS)
                        state <= S_OP_HI;
                    else if (dec.mode == M_ZP && needs_read)
                        state <= S_READ;
                    else
                        state <= S_EXEC;
                end
                S_OP_HI: begin
                    ophi  <= rdata;
                    pc    <= pc + 16'd1;
                    state <= needs_read ? S_READ : S_EXEC;
                end
                S_READ: begin
                    md    <= rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (dec.op)
                        O_LD: begin
                            case (dec.rsel)
                                R_X:     x <= md;
                                R_Y:     y <= md;
                                default: a <= md;
                            endcase
                            z <= (md == 8'h00);
                            n <= md[7];
                        end
                        O_ST: begin
                            md    <= st_val;
                            state <= S_WRITE;
                        end
                        O_ASL, O_LSR, O_ROL, O_ROR: begin
                            c <= sh_c;
                            z <= (sh_res == 8'h00);
                            n <= sh_res[7];
                            if (dec.mode == M_IMP) begin
                                a <= sh_res;
                            end else begin
                                md    <= sh_res;
                                state <= S_WRITE;
                            end
                        end
                        O_CLC: c  <= 1'b0;
                        O_SEC: c  <= 1'b1;
                        O_JMP: pc <= ea;
                        default: ;
                    endcase
                end
                S_WRITE: state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_cpu_top.sv
// Directed bench for shift_cpu_top: programs are placed in ROM, results read from RAM/registers.
// Latency: each check waits a hand-counted number of ph1 cycles.
// Backpressure: not applicable.
module tb_shift_cpu_top;
    logic        ph1 = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc;
    logic        halted;

    int total = 0;
    int bad = 0;
    int wp = 0;
    logic [7:0] snap [0:511];

    shift_cpu_top dut (
        .ph1    (ph1),
        .reset  (reset),
        .pc     (pc),
        .halted (halted)
    );

    always #5 ph1 = ~ph1;

    task automatic cycles(input int k);
        repeat (k) @(negedge ph1);
    endtask

    // Hold reset, fill ROM with an illegal opcode so runaway code halts, point the vector at $F000.
    task automatic start_prog();
        reset = 1'b0;
        cycles(2);
        for (int i = 0; i < 4096; i++) dut.mem.ROM[i] = 8'h02;
        dut.mem.ROM[12'hFFC] = 8'h00;
        dut.mem.ROM[12'hFFD] = 8'hF0;
        wp = 0;
    endtask

    task automatic emit(input logic [7:0] b);
        dut.mem.ROM[wp] = b;
        wp++;
    endtask

    task automatic test_reset();
        start_prog();
        emit(8'hEA);
        total++; if (pc !== 16'h0000) begin $display("FAIL rst_pc got=%h want=0000", pc); bad++; end
        total++; if (halted !== 1'b0) begin $display("FAIL rst_halted got=%b want=0", halted); bad++; end
        total++; if (dut.a !== 8'h00) begin $display("FAIL rst_a got=%h want=00", dut.a); bad++; end
        total++; if (dut.c !== 1'b0) begin $display("FAIL rst_c got=%b want=0", dut.c); bad++; end
        reset = 1'b1;
        cycles(1);
        total++; if (pc !== 16'h0000) begin $display("FAIL vec_mid_pc got=%h want=0000", pc); bad++; end
        cycles(1);
        total++; if (pc !== 16'hF000) begin $display("FAIL vec_pc got=%h want=F000", pc); bad++; end
    endtask

    task automatic test_asl_acc();
        start_prog();
        emit(8'hA9); emit(8'h37);                 // LDA #$37
        emit(8'h0A);                              // ASL A
        emit(8'h8D); emit(8'hDD); emit(8'h01);    // STA $01DD
        emit(8'h4C); emit(8'h06); emit(8'hF0);    // JMP $F006
        reset = 1'b1;
        cycles(40);
        total++; if (dut.mem.RAM[477] !== 8'h6E) begin $display("FAIL asl_ram got=%h want=6E", dut.mem.RAM[477]); bad++; end
        total++; if (dut.a !== 8'h6E) begin $display("FAIL asl_a got=%h want=6E", dut.a); bad++; end
        total++; if (dut.c !== 1'b0) begin $display("FAIL asl_c got=%b want=0", dut.c); bad++; end
        total++; if (halted !== 1'b0) begin $display("FAIL asl_halted got=%b want=0", halted); bad++; end
    endtask

    task automatic test_rotate();
        start_prog();
        emit(8'h38);                              // SEC
        emit(8'hA9); emit(8'h81);                 // LDA #$81
        emit(8'h2A);                              // ROL A
        emit(8'h6A);                              // ROR A
        emit(8'h02);
        reset = 1'b1;
        cycles(9);
        total++; if (dut.a !== 8'h03) begin $display("FAIL rol_a got=%h want=03", dut.a); bad++; end
        total++; if (dut.c !== 1'b1) begin $display("FAIL rol_c got=%b want=1", dut.c); bad++; end
        total++; if (dut.n !== 1'b0) begin $display("FAIL rol_n got=%b want=0", dut.n); bad++; end
        total++; if (dut.z !== 1'b0) begin $display("FAIL rol_z got=%b want=0", dut.z); bad++; end
        cycles(2);
        total++; if (dut.a !== 8'h81) begin $display("FAIL ror_a got=%h want=81", dut.a); bad++; end
        total++; if (dut.c !== 1'b1) begin $display("FAIL ror_c got=%b want=1", dut.c); bad++; end
        total++; if (dut.n !== 1'b1) begin $display("FAIL ror_n got=%b want=1", dut.n); bad++; end
        cycles(1);
        total++; if (halted !== 1'b1) begin $display("FAIL rot_halted got=%b want=1", halted); bad++; end
    endtask

    task automatic test_mem_shift();
        start_prog();
        emit(8'hA9); emit(8'h01);                 // LDA #$01
        emit(8'h85); emit(8'h10);                 // STA $10
        emit(8'h46); emit(8'h10);                 // LSR $10
        emit(8'h0E); emit(8'h10); emit(8'h00);    // ASL $0010
        emit(8'h02);
        reset = 1'b1;
        cycles(9);
        total++; if (dut.mem.RAM[16] !== 8'h01) begin $display("FAIL sta_zp got=%h want=01", dut.mem.RAM[16]); bad++; end
        cycles(5);
        total++; if (dut.mem.RAM[16] !== 8'h00) begin $display("FAIL lsr_ram got=%h want=00", dut.mem.RAM[16]); bad++; end
        total++; if (dut.c !== 1'b1) begin $display("FAIL lsr_c got=%b want=1", dut.c); bad++; end
        total++; if (dut.z !== 1'b1) begin $display("FAIL lsr_z got=%b want=1", dut.z); bad++; end
        total++; if (dut.n !== 1'b0) begin $display("FAIL lsr_n got=%b want=0", dut.n); bad++; end
        cycles(6);
        total++; if (dut.mem.RAM[16] !== 8'h00) begin $display("FAIL asl_abs_ram got=%h want=00", dut.mem.RAM[16]); bad++; end
        total++; if (dut.c !== 1'b0) begin $display("FAIL asl_abs_c got=%b want=0", dut.c); bad++; end
        cycles(1);
        total++; if (halted !== 1'b1) begin $display("FAIL mem_halted got=%b want=1", halted); bad++; end
    endtask

    task automatic test_halt();
        int diffs;
        start_prog();
        for (int i = 0; i < 5; i++) emit(8'hEA);
        emit(8'h02);
        for (int i = 0; i < 512; i++) snap[i] = dut.mem.RAM[i];
        reset = 1'b1;
        cycles(12);
        total++; if (pc !== 16'hF005 || halted !== 1'b0) begin $display("FAIL pre_halt pc=%h halted=%b want F005/0", pc, halted); bad++; end
        cycles(1);
        total++; if (halted !== 1'b1) begin $display("FAIL halt_flag got=%b want=1", halted); bad++; end
        total++; if (pc !== 16'hF006) begin $display("FAIL halt_pc got=%h want=F006", pc); bad++; end
        cycles(10);
        total++; if (pc !== 16'hF006) begin $display("FAIL halt_pc_frozen got=%h want=F006", pc); bad++; end
        diffs = 0;
        for (int i = 0; i < 512; i++) if (dut.mem.RAM[i] !== snap[i]) diffs++;
        total++; if (diffs != 0) begin $display("FAIL halt_ram_writes got=%0d want=0", diffs); bad++; end
    endtask

    task automatic test_reset_mid();
        start_prog();
        emit(8'hA9); emit(8'h40);                 // LDA #$40
        emit(8'h85); emit(8'h10);                 // STA $10
        emit(8'h06); emit(8'h10);                 // ASL $10
        emit(8'h02);
        reset = 1'b1;
        cycles(9);
        total++; if (dut.mem.RAM[16] !== 8'h40) begin $display("FAIL mid_setup got=%h want=40", dut.mem.RAM[16]); bad++; end
        cycles(2);                                // ASL now in READ
        reset = 1'b0;
        cycles(3);
        total++; if (dut.mem.RAM[16] !== 8'h40) begin $display("FAIL abort_read_ram got=%h want=40", dut.mem.RAM[16]); bad++; end
        total++; if (pc !== 16'h0000) begin $display("FAIL abort_pc got=%h want=0000", pc); bad++; end
        reset = 1'b1;
        cycles(2);
        total++; if (pc !== 16'hF000) begin $display("FAIL refetch_pc got=%h want=F000", pc); bad++; end
        cycles(12);
        total++; if (dut.mem.RAM[16] !== 8'h80) begin $display("FAIL rerun_ram got=%h want=80", dut.mem.RAM[16]); bad++; end
        total++; if (dut.n !== 1'b1 || dut.c !== 1'b0) begin $display("FAIL rerun_flags n=%b c=%b want 1/0", dut.n, dut.c); bad++; end
        reset = 1'b0;                             // rerun, abort with ASL in WRITE
        cycles(2);
        reset = 1'b1;
        cycles(13);
        reset = 1'b0;
        cycles(2);
        total++; if (dut.mem.RAM[16] !== 8'h40) begin $display("FAIL abort_write_ram got=%h want=40", dut.mem.RAM[16]); bad++; end
        reset = 1'b1;
    endtask

    task automatic test_index();
        start_prog();
        emit(8'hA2); emit(8'h80);                 // LDX #$80
        emit(8'h86); emit(8'h20);                 // STX $20
        emit(8'hA4); emit(8'h20);                 // LDY $20
        emit(8'h8C); emit(8'h21); emit(8'h01);    // STY $0121
        emit(8'hAD); emit(8'h21); emit(8'h01);    // LDA $0121
        emit(8'h4A);                              // LSR A
        emit(8'h66); emit(8'h20);                 // ROR $20
        emit(8'hAD); emit(8'h34); emit(8'h12);    // LDA $1234 (unmapped)
        emit(8'h02);
        reset = 1'b1;
        cycles(50);
        total++; if (dut.x !== 8'h80) begin $display("FAIL idx_x got=%h want=80", dut.x); bad++; end
        total++; if (dut.y !== 8'h80) begin $display("FAIL idx_y got=%h want=80", dut.y); bad++; end
        total++; if (dut.mem.RAM[9'h121] !== 8'h80) begin $display("FAIL sty_abs got=%h want=80", dut.mem.RAM[9'h121]); bad++; end
        total++; if (dut.mem.RAM[9'h020] !== 8'h40) begin $display("FAIL ror_zp got=%h want=40", dut.mem.RAM[9'h020]); bad++; end
        total++; if (dut.a !== 8'h00) begin $display("FAIL unmapped_a got=%h want=00", dut.a); bad++; end
        total++; if (dut.z !== 1'b1 || dut.n !== 1'b0 || dut.c !== 1'b0) begin $display("FAIL idx_flags z=%b n=%b c=%b want 1/0/0", dut.z, dut.n, dut.c); bad++; end
        total++; if (halted !== 1'b1 || pc !== 16'hF013) begin $display("FAIL idx_end halted=%b pc=%h want 1/F013", halted, pc); bad++; end
    endtask

    initial begin
        test_reset();
        test_asl_acc();
        test_rotate();
        test_mem_shift();
        test_halt();
        test_reset_mid();
        test_index();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
